ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port access controller for the 4096 x 4-bit asynchronous RAM (cs, we, 12-bit address, bidirectional 4-bit data bus). It accepts read and write requests from two independent requesters (A and B) and grants them with round-robin priority. Each granted access is sequenced as a glitch-free setup / strobe / release cycle on the RAM pins, with the tri-state data bus driven only during writes. It sits between the datapath clients and the RAM instance and is the only block allowed to drive the RAM's cs, we, dir and data pins.

## Interface
- AW, 12, RAM address width
- DW, 4, RAM data width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_a / req_b  in  1  access request from requester A / B
- wr_a / wr_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  AW  target address
- wdata_a / wdata_b  in  DW  write data
- ack_a / ack_b  out  1  one-cycle pulse: access complete
- rdata_a / rdata_b  out  DW  registered read data, valid from ack onward
- busy  out  1  high whenever the FSM is not in IDLE
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_dir  out  AW  RAM address
- ram_data  inout  DW  RAM data bus, high-Z unless this block is writing

## Operation
- FSM states: IDLE, SETUP, ACCESS, RELEASE.
- IDLE: if any req is high, pick a winner, latch its wr/addr/wdata and its id into internal registers, then go to SETUP. Otherwise stay in IDLE.
- Arbitration: round-robin on a last-served bit. If only one requester asserts, it wins. If both assert, the one not served last wins. After reset, A wins a tie.
- SETUP: ram_dir = latched addr, ram_we = latched wr, ram_cs = 0. ram_data is driven with latched wdata if the access is a write. Next state ACCESS.
- ACCESS: ram_cs = 1 and all other RAM signals held. On a read, the edge leaving ACCESS captures ram_data into the winner's rdata register. Next state RELEASE.
- RELEASE: ram_cs = 0, with ram_dir, ram_we and ram_data still held. ack of the winner = 1 for this cycle only. The last-served bit updates. Next state IDLE, unconditionally.
- Outside SETUP/ACCESS/RELEASE-of-a-write, ram_data is high-Z. ram_we is 0 in IDLE.
- Requesters hold req, wr, addr and wdata stable until their ack. They must deassert req in the cycle after ack; a req still high in the following IDLE is treated as a new access.
- The non-winning rdata register is never modified.

## Timing
- All RAM outputs, ack_x and busy are registered, or decoded only from the state register and latched registers. No combinational path runs from req/addr inputs to the RAM pins.
- Latency: req sampled high at edge N (in IDLE). SETUP runs N+1, ACCESS N+2, RELEASE/ack N+3. rdata is valid at N+3 and held until the next read by the same port.
- Throughput: one access per 4 cycles. Back-to-back contention alternates A, B, A, B.
- ram_cs is never high while ram_dir, ram_we or ram_data change. Each of these changes only in IDLE or SETUP.
- Reset (asynchronous, any state, including mid-ACCESS):
  - state = IDLE, ram_cs = 0, ram_we = 0, ram_dir = 0, ram_data = Z
  - ack_a = ack_b = 0, busy = 0, rdata_a = rdata_b = 0
  - last-served reset so that A wins the next tie
  - An interrupted write is not retried.
- A request arriving while busy is ignored until the next IDLE.

## Test plan
- Single write then read from A: write 0xA to 0x123, then read 0x123. Required: ack_a at N+3 for each, rdata_a = 0xA, ram_cs high exactly one cycle per access.
- Simultaneous contention: after reset, req_a and req_b both held. A writes 0x5 to 0x000, B writes 0x9 to 0xFFF. Required: A served first, B 4 cycles later. Reading back gives 0x5 and 0x9.
- Fairness: both requesters re-request immediately after every ack for 8 accesses. Required: grant order strictly A, B, A, B…; no ack_a and ack_b in the same cycle.
- Bus discipline: monitor on every cycle. ram_data must be Z whenever the current access is a read or the FSM is in IDLE. ram_dir, ram_we and ram_data must not change while ram_cs = 1.
- Reset mid-ACCESS of a write by B: assert reset during ACCESS. Required: immediately ram_cs = 0, busy = 0, ram_data = Z, no ack_b. After release, req_a and req_b together give A the grant.
- Address extremes and isolation: B reads 0x000 and 0xFFF after prior writes of 0x3 and 0xC. Required: rdata_b = 0x3, then 0xC; rdata_a unchanged throughout.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Two-requester access controller for a 4096 x 4 asynchronous RAM. Requests
// from A and B are granted round-robin; each grant runs a four-cycle
// IDLE -> SETUP -> ACCESS -> RELEASE sequence on the RAM pins so that chip
// select is only ever high while address, write enable and data are stable.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no access in flight; arbitrate and latch the winner's request
// SETUP   | address / we / write data presented, ram_cs low
// ACCESS  | ram_cs high (strobe); read data captured on the exiting edge
// RELEASE | ram_cs low, pins still held, one-cycle ack to the winner
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   req_x, wr_x             request and direction (1 = write) for A / B
//   addr_x, wdata_x         request address and write data for A / B
//   ack_x                   one-cycle completion pulse for A / B
//   rdata_x                 registered read data for A / B
//   busy                    high whenever an access is in flight
//   ram_cs, ram_we, ram_dir RAM chip select, write enable, address
//   ram_data                RAM data bus, driven only during writes
module ram_arbiter #(
  parameter int AW = 12,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          wr_a,
  input  logic          wr_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_a,
  output logic          ack_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          busy,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_dir,
  inout  wire  [DW-1:0] ram_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic          last_b;     // 1 = B was served last, so A wins a tie
  logic          id_q;       // 1 = current access belongs to B
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          wr_active;  // drives both ram_we and the data-bus enable
  logic          cs_q;
  logic          ack_a_q;
  logic          ack_b_q;
  logic          busy_q;
  logic [DW-1:0] rdata_a_q;
  logic [DW-1:0] rdata_b_q;

  logic any_req;
  logic grant_b;

  always_comb begin
    any_req = req_a | req_b;
    grant_b = req_b & (~req_a | ~last_b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and registered RAM-side outputs. Every pin toggles only on
  // a clock edge out of a register, so ram_cs cannot glitch and nothing in
  // the request path reaches the RAM combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b    <= 1'b1;
      id_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_active <= 1'b0;
      cs_q      <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      busy_q    <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      cs_q    <= (state == SETUP);
      ack_a_q <= (state == ACCESS) && !id_q;
      ack_b_q <= (state == ACCESS) &&  id_q;
      busy_q  <= (state_nxt != IDLE);

      case (state)
        IDLE: begin
          if (any_req) begin
            id_q      <= grant_b;
            wr_q      <= grant_b ? wr_b    : wr_a;
            addr_q    <= grant_b ? addr_b  : addr_a;
            wdata_q   <= grant_b ? wdata_b : wdata_a;
            wr_active <= grant_b ? wr_b    : wr_a;
          end
        end
        ACCESS: begin
          if (!wr_q) begin
            if (id_q) rdata_b_q <= ram_data;
            else      rdata_a_q <= ram_data;
          end
        end
        RELEASE: begin
          wr_active <= 1'b0;
          last_b    <= id_q;
        end
        default: ;
      endcase
    end
  end

  assign ram_cs   = cs_q;
  assign ram_we   = wr_active;
  assign ram_dir  = addr_q;
  assign ram_data = wr_active ? wdata_q : {DW{1'bz}};
  assign ack_a    = ack_a_q;
  assign ack_b    = ack_b_q;
  assign busy     = busy_q;
  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Bench for ram_arbiter with an attached behavioural asynchronous RAM. A
// released data bus floats to 4'hF through pull-ups. Expected grants and
// data come from a reference model: an array image of the RAM, the
// last-served requester, and the expected rdata of each port.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, wr_a, wr_b;
  logic [11:0] addr_a, addr_b;
  logic [3:0]  wdata_a, wdata_b;
  logic        ack_a, ack_b, busy, ram_cs, ram_we;
  logic [3:0]  rdata_a, rdata_b;
  logic [11:0] ram_dir;
  wire  [3:0]  ram_data;

  pullup (ram_data[0]);
  pullup (ram_data[1]);
  pullup (ram_data[2]);
  pullup (ram_data[3]);

  ram_arbiter #(.AW(12), .DW(4)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .wr_a(wr_a), .wr_b(wr_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .busy(busy), .ram_cs(ram_cs), .ram_we(ram_we), .ram_dir(ram_dir),
    .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // Asynchronous RAM: drives the bus while selected for a read, stores the
  // bus contents when selected for a write.
  logic [3:0] ram_mem [0:4095];
  assign ram_data = (ram_cs && !ram_we) ? ram_mem[ram_dir] : 4'bz;
  always @(posedge ram_cs) if (ram_we) ram_mem[ram_dir] = ram_data;

  int tests  = 0;
  int failed = 0;

  logic [3:0] mdl_mem [0:4095];
  bit         mdl_last_b;
  logic [3:0] exp_rdata_a, exp_rdata_b;
  bit         mon_en = 1'b0;

  // Bus discipline monitors.
  always @(negedge clk) begin
    if (mon_en && !reset && (!busy || (!ram_we && !ram_cs))) begin
      tests++;
      if (ram_data !== 4'hF) begin
        failed++;
        $display("FAIL bus_release: ram_data=%h required released (F), busy=%b we=%b", ram_data, busy, ram_we);
      end
    end
  end

  always @(ram_dir or ram_we) begin
    if (mon_en && !reset) begin
      tests++;
      if (ram_cs) begin
        failed++;
        $display("FAIL pin_stable: ram_dir=%h ram_we=%b changed while ram_cs=1", ram_dir, ram_we);
      end
    end
  end

  always @(ram_data) begin
    if (mon_en && !reset) begin
      tests++;
      if (ram_cs && ram_we) begin
        failed++;
        $display("FAIL data_stable: ram_data=%h changed during write strobe", ram_data);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    req_a = 0; req_b = 0; wr_a = 0; wr_b = 0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mdl_last_b  = 1'b1;
    exp_rdata_a = '0;
    exp_rdata_b = '0;
  endtask

  // Issue na accesses from A and nb from B. The first access of each port
  // uses the given parameters; a port that still has accesses left keeps req
  // high after its ack with fresh random parameters. Called at a negedge
  // with the DUT idle.
  task automatic xfer(input int na, input int nb, input bit wa, input bit wb,
                      input logic [11:0] aa, input logic [11:0] ab,
                      input logic [3:0] da, input logic [3:0] db);
    int rem_a = na;
    int rem_b = nb;
    bit win_b;
    bit c_wr;
    logic [11:0] c_addr;
    logic [3:0]  c_wd;
    req_a = (na > 0); wr_a = wa; addr_a = aa; wdata_a = da;
    req_b = (nb > 0); wr_b = wb; addr_b = ab; wdata_b = db;
    while (rem_a > 0 || rem_b > 0) begin
      if (rem_a == 0)      win_b = 1'b1;
      else if (rem_b == 0) win_b = 1'b0;
      else                 win_b = !mdl_last_b;
      c_wr   = win_b ? wr_b    : wr_a;
      c_addr = win_b ? addr_b  : addr_a;
      c_wd   = win_b ? wdata_b : wdata_a;
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk); @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
          failed++; $display("FAIL busy_active: cycle %0d busy=%b required 1", k, busy);
        end
        tests++;
        if (ram_cs !== (k == 2)) begin
          failed++; $display("FAIL cs_strobe: cycle %0d ram_cs=%b required %b", k, ram_cs, (k == 2));
        end
        if (k == 2) begin
          tests++;
          if (ram_dir !== c_addr || ram_we !== c_wr) begin
            failed++; $display("FAIL ram_pins: dir=%h we=%b required dir=%h we=%b", ram_dir, ram_we, c_addr, c_wr);
          end
        end
        if (k < 3) begin
          tests++;
          if (ack_a !== 1'b0 || ack_b !== 1'b0) begin
            failed++; $display("FAIL early_ack: cycle %0d acks=%b%b required 00", k, ack_a, ack_b);
          end
        end
      end
      if (c_wr) mdl_mem[c_addr] = c_wd;
      else if (win_b) exp_rdata_b = mdl_mem[c_addr];
      else exp_rdata_a = mdl_mem[c_addr];
      tests++;
      if ({ack_a, ack_b} !== (win_b ? 2'b01 : 2'b10)) begin
        failed++; $display("FAIL grant: acks(a,b)=%b%b required %b", ack_a, ack_b, (win_b ? 2'b01 : 2'b10));
      end
      tests++;
      if (rdata_a !== exp_rdata_a) begin
        failed++; $display("FAIL rdata_a: got %h required %h", rdata_a, exp_rdata_a);
      end
      tests++;
      if (rdata_b !== exp_rdata_b) begin
        failed++; $display("FAIL rdata_b: got %h required %h", rdata_b, exp_rdata_b);
      end
      mdl_last_b = win_b;
      if (win_b) begin
        rem_b--;
        req_b = (rem_b > 0); wr_b = 1'($urandom_range(1, 0));
        addr_b = 12'($urandom_range(4095, 0)); wdata_b = 4'($urandom_range(15, 0));
      end else begin
        rem_a--;
        req_a = (rem_a > 0); wr_a = 1'($urandom_range(1, 0));
        addr_a = 12'($urandom_range(4095, 0)); wdata_a = 4'($urandom_range(15, 0));
      end
      @(posedge clk); @(negedge clk);
      tests++;
      if (busy !== 1'b0 || ack_a !== 1'b0 || ack_b !== 1'b0) begin
        failed++; $display("FAIL back_to_idle: busy=%b acks=%b%b required 0 00", busy, ack_a, ack_b);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (ram_cs !== 0 || ram_we !== 0 || ram_dir !== 12'h000 || ram_data !== 4'hF) begin
      failed++; $display("FAIL reset_pins: cs=%b we=%b dir=%h data=%h required 0 0 000 F", ram_cs, ram_we, ram_dir, ram_data);
    end
    tests++;
    if (ack_a !== 0 || ack_b !== 0 || busy !== 0 || rdata_a !== 4'h0 || rdata_b !== 4'h0) begin
      failed++; $display("FAIL reset_outs: acks=%b%b busy=%b rdata=%h/%h required 00 0 0/0", ack_a, ack_b, busy, rdata_a, rdata_b);
    end
  endtask

  task automatic test_single_a();
    xfer(1, 0, 1'b1, 1'b0, 12'h123, 12'h000, 4'hA, 4'h0);
    xfer(1, 0, 1'b0, 1'b0, 12'h123, 12'h000, 4'($urandom_range(14, 0)), 4'h0);
    tests++;
    if (rdata_a !== 4'hA) begin
      failed++; $display("FAIL single_read: rdata_a=%h required A", rdata_a);
    end
  endtask

  task automatic test_contention();
    do_reset();
    xfer(1, 1, 1'b1, 1'b1, 12'h000, 12'hFFF, 4'h5, 4'h9);
    xfer(1, 0, 1'b0, 1'b0, 12'h000, 12'h000, 4'h0, 4'h0);
    tests++;
    if (rdata_a !== 4'h5) begin
      failed++; $display("FAIL contention_a: rdata_a=%h required 5", rdata_a);
    end
    xfer(0, 1, 1'b0, 1'b0, 12'h000, 12'hFFF, 4'h0, 4'h0);
    tests++;
    if (rdata_b !== 4'h9) begin
      failed++; $display("FAIL contention_b: rdata_b=%h required 9", rdata_b);
    end
  endtask

  task automatic test_fairness();
    xfer(4, 4, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
         12'($urandom_range(4095, 0)), 12'($urandom_range(4095, 0)),
         4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
  endtask

  task automatic test_random();
    int na, nb;
    repeat (12) begin
      na = $urandom_range(2, 0);
      nb = $urandom_range(2, 0);
      if (na == 0 && nb == 0) na = 1;
      xfer(na, nb, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           12'($urandom_range(63, 0)), 12'($urandom_range(63, 0)),
           4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
    end
  endtask

  task automatic test_reset_mid_access();
    req_b = 1'b1; wr_b = 1'b1; addr_b = 12'h777; wdata_b = 4'h6;
    @(posedge clk); @(posedge clk);
    #2;
    tests++;
    if (ram_cs !== 1'b1) begin
      failed++; $display("FAIL pre_reset_strobe: ram_cs=%b required 1", ram_cs);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (ram_cs !== 0 || busy !== 0 || ram_data !== 4'hF || ack_b !== 0 || ram_we !== 0 || ram_dir !== 12'h000) begin
      failed++; $display("FAIL mid_reset: cs=%b busy=%b data=%h ack_b=%b we=%b dir=%h required 0 0 F 0 0 000",
                         ram_cs, busy, ram_data, ack_b, ram_we, ram_dir);
    end
    req_b = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    // The bench RAM stores on the rising strobe, so that write landed.
    mdl_mem[12'h777] = 4'h6;
    mdl_last_b  = 1'b1;
    exp_rdata_a = '0;
    exp_rdata_b = '0;
    repeat (4) begin
      @(negedge clk);
      tests++;
      if (ack_b !== 1'b0 || busy !== 1'b0) begin
        failed++; $display("FAIL no_retry: ack_b=%b busy=%b required 0 0", ack_b, busy);
      end
    end
    xfer(1, 1, 1'b0, 1'b0, 12'h777, 12'h777, 4'h0, 4'h0);
  endtask

  task automatic test_extremes();
    logic [3:0] keep_a;
    xfer(1, 0, 1'b1, 1'b0, 12'h000, 12'h000, 4'h3, 4'h0);
    xfer(1, 0, 1'b1, 1'b0, 12'hFFF, 12'h000, 4'hC, 4'h0);
    keep_a = exp_rdata_a;
    xfer(0, 1, 1'b0, 1'b0, 12'h000, 12'h000, 4'h0, 4'h0);
    tests++;
    if (rdata_b !== 4'h3) begin
      failed++; $display("FAIL extreme_low: rdata_b=%h required 3", rdata_b);
    end
    xfer(0, 1, 1'b0, 1'b0, 12'h000, 12'hFFF, 4'h0, 4'h0);
    tests++;
    if (rdata_b !== 4'hC) begin
      failed++; $display("FAIL extreme_high: rdata_b=%h required C", rdata_b);
    end
    tests++;
    if (rdata_a !== keep_a) begin
      failed++; $display("FAIL isolation_a: rdata_a=%h required %h", rdata_a, keep_a);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = 4'h0;
      mdl_mem[i] = 4'h0;
    end
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    mon_en = 1'b1;
    test_single_a();
    test_contention();
    test_fairness();
    test_random();
    test_reset_mid_access();
    test_extremes();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
